// File: rtl/mux_ndff_pkg.sv
// Shared constants for the mux-recirculation CDC receiver.
package mux_ndff_pkg;

    // Capture qualifier modes
    localparam int EN_MODE_EDGE    = 0;  // rising edge of en captures
    localparam int EN_MODE_TOGGLE  = 1;  // any transition of en captures

    // Legal synchroniser depths
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Width of the per-channel gap counter; at least one bit so a disabled
    // gap check still elaborates to a legal (constant-zero) register.
    function automatic int gap_width(input int min_gap);
        return (min_gap > 0) ? $clog2(min_gap + 1) : 1;
    endfunction

endpackage

// File: rtl/mux_ndff_edge_sync.sv
// Per-channel enable synchroniser, edge register, post-reset priming and
// capture-pulse generation.
module mux_ndff_edge_sync
    import mux_ndff_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EN_MODE     = EN_MODE_EDGE
) (
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    output logic pulse_o
);

    localparam int                 PRIME_W    = $clog2(SYNC_STAGES_MAX + 2);
    localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(SYNC_STAGES + 1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic               s_d_q;
    logic [PRIME_W-1:0] prime_q;
    logic [PRIME_W-1:0] prime_d;
    logic               s;
    logic               edge_det;

    assign s = sync_q[SYNC_STAGES-1];

    // Priming counter counts down to zero after reset and then rests there
    always_comb begin
        prime_d = prime_q;
        if (prime_q != '0) begin
            prime_d = prime_q - PRIME_W'(1);
        end
    end

    // Synchroniser chain, edge register and priming counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q  <= '0;
            s_d_q   <= 1'b0;
            prime_q <= PRIME_LOAD;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], en_i};
            s_d_q   <= s;
            prime_q <= prime_d;
        end
    end

    // The edge register tracks the chain during priming, so a level held
    // across reset is absorbed before pulses are allowed out.
    assign edge_det = (EN_MODE == EN_MODE_TOGGLE) ? (s ^ s_d_q) : (s & ~s_d_q);
    assign pulse_o  = edge_det & (prime_q == '0);

endmodule

// File: rtl/macro_mux_ndff_multi.sv
// Multi-channel mux-recirculation CDC receiver (clkb domain): per channel an
// enable is synchronised and edge-detected, and the resulting pulse loads the
// channel's data bus into a holding register, with overrun and data-stability
// checking.
module macro_mux_ndff_multi
    import mux_ndff_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int WIDTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int EN_MODE      = 0,
    parameter int MIN_GAP      = 4,
    parameter int CHECK_STABLE = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_CH*WIDTH-1:0] data,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       clr_err,
    output logic [NUM_CH*WIDTH-1:0] data_sync,
    output logic [NUM_CH-1:0]       data_vld,
    output logic [NUM_CH-1:0]       overrun,
    output logic [NUM_CH-1:0]       mismatch
);

    localparam int               GAP_W    = gap_width(MIN_GAP);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("macro_mux_ndff_multi: SYNC_STAGES=%0d outside %0d..%0d",
               SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end

    if (EN_MODE != EN_MODE_EDGE && EN_MODE != EN_MODE_TOGGLE) begin : g_bad_mode
        $error("macro_mux_ndff_multi: EN_MODE=%0d outside 0..1", EN_MODE);
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             pulse;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] cap_q;
        logic [WIDTH-1:0] cap_d;
        logic             vld_q;
        logic [GAP_W-1:0] gap_q;
        logic [GAP_W-1:0] gap_d;
        logic             ovr_q;
        logic             ovr_d;
        logic             mis_q;
        logic             mis_d;

        mux_ndff_edge_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .EN_MODE     (EN_MODE)
        ) u_edge_sync (
            .clk     (clk),
            .rstn    (rstn),
            .en_i    (en[c]),
            .pulse_o (pulse)
        );

        assign din = data[c*WIDTH +: WIDTH];

        // Next-state for capture, gap counter and sticky error flags
        always_comb begin
            cap_d = cap_q;
            gap_d = gap_q;
            ovr_d = ovr_q;
            mis_d = mis_q;

            if (gap_q != '0) begin
                gap_d = gap_q - GAP_W'(1);
            end

            // Clear first so that a coincident set takes priority
            if (clr_err[c]) begin
                ovr_d = 1'b0;
                mis_d = 1'b0;
            end

            if (pulse) begin
                cap_d = din;
                gap_d = GAP_LOAD;
                if (gap_q != '0) begin
                    ovr_d = 1'b1;
                end
            end

            // One cycle after a capture the source must still present the
            // captured word; the holding register is deliberately not refreshed.
            if ((CHECK_STABLE != 0) && vld_q && (din != cap_q)) begin
                mis_d = 1'b1;
            end
        end

        // Per-channel state registers
        always_ff @(posedge clk) begin
            if (!rstn) begin
                cap_q <= '0;
                vld_q <= 1'b0;
                gap_q <= '0;
                ovr_q <= 1'b0;
                mis_q <= 1'b0;
            end else begin
                cap_q <= cap_d;
                vld_q <= pulse;
                gap_q <= gap_d;
                ovr_q <= ovr_d;
                mis_q <= mis_d;
            end
        end

        assign data_sync[c*WIDTH +: WIDTH] = cap_q;
        assign data_vld[c]                 = vld_q;
        assign overrun[c]                  = ovr_q;
        assign mismatch[c]                 = mis_q;
    end

endmodule

// File: tb/tb_macro_mux_ndff_multi.sv
// Bench for macro_mux_ndff_multi: one instance in edge mode, one in toggle mode.
module tb_macro_mux_ndff_multi;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NCH*W-1:0]   data;
    logic [NCH-1:0]     en0;
    logic [NCH-1:0]     en1;
    logic [NCH-1:0]     clr_err;
    logic [NCH*W-1:0]   ds0;
    logic [NCH*W-1:0]   ds1;
    logic [NCH-1:0]     vld0;
    logic [NCH-1:0]     vld1;
    logic [NCH-1:0]     ovr0;
    logic [NCH-1:0]     ovr1;
    logic [NCH-1:0]     mis0;
    logic [NCH-1:0]     mis1;

    typedef struct {
        int         id;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   vld_cnt[8];

    always #5 clk = ~clk;

    macro_mux_ndff_multi #(
        .NUM_CH(NCH), .WIDTH(W), .SYNC_STAGES(2), .EN_MODE(0), .MIN_GAP(4), .CHECK_STABLE(1)
    ) dut0 (
        .clk(clk), .rstn(rstn), .data(data), .en(en0), .clr_err(clr_err),
        .data_sync(ds0), .data_vld(vld0), .overrun(ovr0), .mismatch(mis0)
    );

    macro_mux_ndff_multi #(
        .NUM_CH(NCH), .WIDTH(W), .SYNC_STAGES(2), .EN_MODE(1), .MIN_GAP(4), .CHECK_STABLE(1)
    ) dut1 (
        .clk(clk), .rstn(rstn), .data(data), .en(en1), .clr_err(clr_err),
        .data_sync(ds1), .data_vld(vld1), .overrun(ovr1), .mismatch(mis1)
    );

    // Scoreboard monitor: every strobe must match the oldest expected word
    // for that instance/channel.
    always @(negedge clk) begin
        logic [NCH-1:0]   v;
        logic [NCH*W-1:0] ds;
        int               idx;
        for (int d = 0; d < 2; d++) begin
            v  = (d == 0) ? vld0 : vld1;
            ds = (d == 0) ? ds0 : ds1;
            for (int c = 0; c < NCH; c++) begin
                if (v[c]) begin
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (idx < 0 && sb[i].id == d*4 + c) idx = i;
                    end
                    vld_cnt[d*4 + c]++;
                    n_cmp++;
                    if (idx < 0) begin
                        n_mis++;
                        $display("FAIL sb_unexpected_vld dut%0d ch%0d: got strobe with data %h, required no strobe",
                                 d, c, ds[c*W +: W]);
                    end else begin
                        if (ds[c*W +: W] !== sb[idx].d) begin
                            n_mis++;
                            $display("FAIL sb_data dut%0d ch%0d: got %h, required %h",
                                     d, c, ds[c*W +: W], sb[idx].d);
                        end
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [7:0] d);
        exp_t e;
        e.id = id;
        e.d  = d;
        sb.push_back(e);
    endtask

    task automatic set_data(input int c, input logic [7:0] v);
        data[c*W +: W] = v;
    endtask

    task automatic test_reset();
        rstn = 1'b0; data = '0; en0 = '0; en1 = '0; clr_err = '0;
        step();
        en0[0] = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (ds0 !== '0 || ds1 !== '0) begin
            n_mis++;
            $display("FAIL reset_data_sync: got %h/%h, required 0", ds0, ds1);
        end
        n_cmp++;
        if ({vld0, vld1, ovr0, ovr1, mis0, mis1} !== '0) begin
            n_mis++;
            $display("FAIL reset_flags: got %h, required 0", {vld0, vld1, ovr0, ovr1, mis0, mis1});
        end
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (vld0[0] !== 1'b0 || ds0[7:0] !== 8'h00) begin
                n_mis++;
                $display("FAIL prime_no_capture cycle %0d: got vld=%b data=%h, required vld=0 data=00",
                         i, vld0[0], ds0[7:0]);
            end
        end
        en0[0] = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_basic_edge();
        set_data(1, 8'hA5);
        en0[1] = 1'b1;
        push(1, 8'hA5);
        step(); step();
        n_cmp++;
        if (ds0[15:8] !== 8'h00) begin
            n_mis++;
            $display("FAIL basic_early: got %h, required 00", ds0[15:8]);
        end
        step();
        n_cmp++;
        if (ds0[15:8] !== 8'hA5 || vld0[1] !== 1'b1) begin
            n_mis++;
            $display("FAIL basic_capture: got data=%h vld=%b, required data=a5 vld=1", ds0[15:8], vld0[1]);
        end
        step();
        n_cmp++;
        if (vld0[1] !== 1'b0 || ds0[15:8] !== 8'hA5) begin
            n_mis++;
            $display("FAIL basic_vld_one_cycle: got vld=%b data=%h, required vld=0 data=a5", vld0[1], ds0[15:8]);
        end
        en0[1] = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_toggle();
        logic [7:0] vals[3];
        int         cnt_before;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        cnt_before = vld_cnt[6];
        for (int i = 0; i < 3; i++) begin
            set_data(2, vals[i]);
            en1[2] = ~en1[2];
            push(6, vals[i]);
            repeat (8) step();
        end
        n_cmp++;
        if (vld_cnt[6] - cnt_before !== 3) begin
            n_mis++;
            $display("FAIL toggle_strobes: got %0d, required 3", vld_cnt[6] - cnt_before);
        end
        n_cmp++;
        if (ds1[23:16] !== 8'h33 || ovr1[2] !== 1'b0) begin
            n_mis++;
            $display("FAIL toggle_final: got data=%h ovr=%b, required data=33 ovr=0", ds1[23:16], ovr1[2]);
        end
    endtask

    task automatic test_overrun();
        // Captures three cycles apart
        set_data(0, 8'h31); en0[0] = 1'b1; push(0, 8'h31);
        step(); step();
        en0[0] = 1'b0;
        step();
        en0[0] = 1'b1;
        step();
        set_data(0, 8'h32); push(0, 8'h32);
        step(); step();
        n_cmp++;
        if (ovr0[0] !== 1'b1 || ds0[7:0] !== 8'h32) begin
            n_mis++;
            $display("FAIL overrun_set: got ovr=%b data=%h, required ovr=1 data=32", ovr0[0], ds0[7:0]);
        end
        repeat (3) step();
        n_cmp++;
        if (ovr0[0] !== 1'b1) begin
            n_mis++;
            $display("FAIL overrun_sticky: got %b, required 1", ovr0[0]);
        end
        clr_err[0] = 1'b1; step(); clr_err[0] = 1'b0;
        n_cmp++;
        if (ovr0[0] !== 1'b0) begin
            n_mis++;
            $display("FAIL overrun_clear: got %b, required 0", ovr0[0]);
        end
        en0[0] = 1'b0;
        repeat (6) step();
        // Captures six cycles apart
        set_data(0, 8'h41); en0[0] = 1'b1; push(0, 8'h41);
        step(); step();
        en0[0] = 1'b0;
        repeat (4) step();
        en0[0] = 1'b1;
        step();
        set_data(0, 8'h42); push(0, 8'h42);
        step(); step();
        n_cmp++;
        if (ovr0[0] !== 1'b0 || ds0[7:0] !== 8'h42) begin
            n_mis++;
            $display("FAIL overrun_wide_gap: got ovr=%b data=%h, required ovr=0 data=42", ovr0[0], ds0[7:0]);
        end
        en0[0] = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_mismatch();
        set_data(3, 8'h0F); en0[3] = 1'b1; push(3, 8'h0F);
        repeat (3) step();
        set_data(3, 8'hF0);
        step();
        n_cmp++;
        if (mis0[3] !== 1'b1 || ds0[31:24] !== 8'h0F) begin
            n_mis++;
            $display("FAIL mismatch_set: got mis=%b data=%h, required mis=1 data=0f", mis0[3], ds0[31:24]);
        end
        en0[3] = 1'b0;
        repeat (5) step();
        // New mismatch coinciding with a clear: set wins
        en0[3] = 1'b1; push(3, 8'hF0);
        repeat (3) step();
        set_data(3, 8'h0F); clr_err[3] = 1'b1;
        step();
        clr_err[3] = 1'b0;
        n_cmp++;
        if (mis0[3] !== 1'b1 || ds0[31:24] !== 8'hF0) begin
            n_mis++;
            $display("FAIL mismatch_set_wins: got mis=%b data=%h, required mis=1 data=f0", mis0[3], ds0[31:24]);
        end
        clr_err[3] = 1'b1; step(); clr_err[3] = 1'b0;
        n_cmp++;
        if (mis0[3] !== 1'b0 || ovr0[3] !== 1'b0) begin
            n_mis++;
            $display("FAIL mismatch_clear: got mis=%b ovr=%b, required 0/0", mis0[3], ovr0[3]);
        end
        en0[3] = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_back_to_back();
        data = 32'hD4C3B2A1;
        for (int c = 0; c < NCH; c++) push(c, data[c*W +: W]);
        en0 = 4'hF;
        repeat (3) step();
        n_cmp++;
        if (vld0 !== 4'hF || ds0 !== 32'hD4C3B2A1) begin
            n_mis++;
            $display("FAIL multi_channel: got vld=%h data=%h, required vld=f data=d4c3b2a1", vld0, ds0);
        end
        step();
        n_cmp++;
        if (ovr0 !== 4'h0 || mis0 !== 4'h0 || vld0 !== 4'h0) begin
            n_mis++;
            $display("FAIL multi_flags: got ovr=%h mis=%h vld=%h, required 0/0/0", ovr0, mis0, vld0);
        end
        en0 = 4'h0;
        repeat (6) step();
    endtask

    task automatic test_reset_midflight();
        set_data(0, 8'h77);
        en0[0] = 1'b1;
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if ({ds0, vld0, ovr0, mis0} !== '0 || {ds1, vld1, ovr1, mis1} !== '0) begin
                n_mis++;
                $display("FAIL midflight_reset cycle %0d: got ds0=%h vld0=%h ds1=%h vld1=%h, required all 0",
                         i, ds0, vld0, ds1, vld1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_edge();
        test_toggle();
        test_overrun();
        test_mismatch();
        test_back_to_back();
        test_reset_midflight();
        n_cmp++;
        if (sb.size() !== 0) begin
            n_mis++;
            $display("FAIL sb_drain: got %0d outstanding captures, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
